call_stack_ctrl: RTL and testbench

Sequencer that saves and restores a PC_WIDTH-bit return address on the nibble-wide hardware stack during CALL/RET. It splits each address into DATA_SIZE-bit slices and drives the stack write/read strobes for one cycle per slice. It reassembles popped slices, tracks frame depth, and flags overflow or underflow before any stack access is made. It sits between the CPU control unit and the stack instance at CPU top level.

---
 rtl/call_stack_pkg.sv | 13 +
 rtl/call_stack_ctrl.sv | 90 +++++++++
 tb/tb_call_stack_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/call_stack_pkg.sv
// call_stack_pkg: shared state encoding and size helpers for call_stack_ctrl.
package call_stack_pkg;
    typedef enum logic [2:0] {IDLE, PUSH, POP, DRAIN, FIN} state_t;
    function automatic int nibbles(int pc_w, int data_w);
        return pc_w / data_w;
    endfunction
    function automatic int max_frames(int stack_size, int pc_w, int data_w);
        return (2 ** stack_size - 1) / nibbles(pc_w, data_w);
    endfunction
    function automatic int depth_w(int frames);
        return $clog2(frames + 1);
    endfunction
endpackage

// File: rtl/call_stack_ctrl.sv
// call_stack_ctrl: saves/restores return addresses on a slice-wide stack during CALL/RET.
// Define CALL_STACK_WATERMARK_EN to build the MAX_DEPTH high-water register.
module call_stack_ctrl
    import call_stack_pkg::*;
#(
    parameter int DATA_SIZE = 4,
    parameter int STACK_SIZE = 5,
    parameter int PC_WIDTH = 8,
    localparam int DW = depth_w(max_frames(STACK_SIZE, PC_WIDTH, DATA_SIZE))
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic                 CALL_REQ,
    input  logic                 RET_REQ,
    input  logic [PC_WIDTH-1:0]  PC_IN,
    output logic [PC_WIDTH-1:0]  RET_PC,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 ERR_OVF,
    output logic                 ERR_UNF,
    output logic [DW-1:0]        DEPTH,
    output logic [DW-1:0]        MAX_DEPTH,
    output logic                 STK_W,
    output logic                 STK_R,
    output logic [DATA_SIZE-1:0] STK_DATA_WR,
    input  logic [DATA_SIZE-1:0] STK_DATA_RD
);
    localparam int NIB = nibbles(PC_WIDTH, DATA_SIZE);
    localparam int CW = NIB > 1 ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);
    localparam logic [DW-1:0] FULL = DW'(max_frames(STACK_SIZE, PC_WIDTH, DATA_SIZE));

    state_t state, nxt;
    logic [CW-1:0] cnt;
    logic [PC_WIDTH-1:0] shreg, asm_r;
    logic last;

    assign last = cnt == LAST;

    always_ff @(posedge CLK or negedge RSTN)
        if (!RSTN) state <= IDLE;
        else state <= nxt;

    always_comb begin
        nxt = state;
        case (state)
            IDLE: nxt = CALL_REQ ? (DEPTH == FULL ? IDLE : PUSH) : (RET_REQ && DEPTH != '0 ? POP : IDLE);
            PUSH: nxt = last ? FIN : PUSH;
            POP: nxt = last ? DRAIN : POP;
            DRAIN: nxt = FIN;
            default: nxt = IDLE;
        endcase
        STK_W = state == PUSH;
        STK_R = state == POP;
        BUSY = state == PUSH || state == POP || state == DRAIN;
        DONE = state == FIN;
        STK_DATA_WR = state == PUSH ? shreg[DATA_SIZE-1:0] : '0;
    end

    // Popped slices arrive most-significant first, so they enter at the bottom and move up.
    always_ff @(posedge CLK or negedge RSTN)
        if (!RSTN) begin
            cnt <= '0;
            shreg <= '0;
            asm_r <= '0;
            RET_PC <= '0;
            DEPTH <= '0;
            ERR_OVF <= 1'b0;
            ERR_UNF <= 1'b0;
        end else begin
            ERR_OVF <= state == IDLE && CALL_REQ && DEPTH == FULL;
            ERR_UNF <= state == IDLE && !CALL_REQ && RET_REQ && DEPTH == '0;
            cnt <= (state == PUSH || state == POP) && !last ? cnt + CW'(1) : '0;
            shreg <= state == IDLE ? PC_IN : shreg >> DATA_SIZE;
            if (state == POP && cnt != '0) asm_r <= (asm_r << DATA_SIZE) | PC_WIDTH'(STK_DATA_RD);
            if (state == DRAIN) begin
                RET_PC <= (asm_r << DATA_SIZE) | PC_WIDTH'(STK_DATA_RD);
                DEPTH <= DEPTH - DW'(1);
            end
            if (state == PUSH && last) DEPTH <= DEPTH + DW'(1);
        end

`ifdef CALL_STACK_WATERMARK_EN
    always_ff @(posedge CLK or negedge RSTN)
        if (!RSTN) MAX_DEPTH <= '0;
        else if (state == PUSH && last && DEPTH >= MAX_DEPTH) MAX_DEPTH <= DEPTH + DW'(1);
`else
    assign MAX_DEPTH = '0;
`endif
endmodule

// File: tb/tb_call_stack_ctrl.sv
// tb_call_stack_ctrl: scoreboard bench with a LIFO reference model and a behavioural stack.
module tb_call_stack_ctrl;
    localparam int MAXF = 15;
`ifdef CALL_STACK_WATERMARK_EN
    localparam bit WM = 1'b1;
`else
    localparam bit WM = 1'b0;
`endif

    logic CLK = 1'b0, RSTN = 1'b0, CALL_REQ = 1'b0, RET_REQ = 1'b0;
    logic [7:0] PC_IN = '0, RET_PC;
    logic BUSY, DONE, ERR_OVF, ERR_UNF, STK_W, STK_R;
    logic [3:0] DEPTH, MAX_DEPTH, STK_DATA_WR, STK_DATA_RD;

    typedef struct {
        logic [2:0] code;
        logic [7:0] pc;
        logic [7:0] ret;
        int depth;
        int maxd;
        int lat;
        int acc;
        bit is_call;
        bit is_ret;
    } exp_t;

    exp_t sb[$];
    logic [7:0] model[$];
    int wm = 0;
    logic [7:0] last_ret = '0;
    int tests = 0, fails = 0, cyc = 0;

    call_stack_ctrl dut (
        .CLK(CLK), .RSTN(RSTN), .CALL_REQ(CALL_REQ), .RET_REQ(RET_REQ), .PC_IN(PC_IN),
        .RET_PC(RET_PC), .BUSY(BUSY), .DONE(DONE), .ERR_OVF(ERR_OVF), .ERR_UNF(ERR_UNF),
        .DEPTH(DEPTH), .MAX_DEPTH(MAX_DEPTH), .STK_W(STK_W), .STK_R(STK_R),
        .STK_DATA_WR(STK_DATA_WR), .STK_DATA_RD(STK_DATA_RD)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    logic [3:0] mem [0:31];
    logic [4:0] sp;
    always @(posedge CLK or negedge RSTN)
        if (!RSTN) begin
            sp <= '0;
            STK_DATA_RD <= '0;
        end else if (STK_W) begin
            mem[sp] <= STK_DATA_WR;
            sp <= sp + 5'd1;
        end else if (STK_R) begin
            STK_DATA_RD <= mem[sp - 5'd1];
            sp <= sp - 5'd1;
        end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    int nw = 0, nr = 0;
    logic [7:0] wacc = '0;
    exp_t m;
    always @(negedge CLK) begin
        if (!RSTN) begin
            nw = 0;
            nr = 0;
            wacc = '0;
        end else begin
            if (STK_W && STK_R) chk("strobe_exclusive", 1, 0);
            if (STK_W) begin
                wacc = wacc | (8'(STK_DATA_WR) << (4 * nw));
                nw++;
            end
            if (STK_R) nr++;
            if (DONE || ERR_OVF || ERR_UNF) begin
                if (sb.size() == 0) chk("unexpected_response", {ERR_UNF, ERR_OVF, DONE}, 0);
                else begin
                    m = sb.pop_front();
                    chk("response_code", {ERR_UNF, ERR_OVF, DONE}, m.code);
                    chk("latency", cyc - m.acc + 1, m.lat);
                    chk("depth", DEPTH, m.depth);
                    chk("max_depth", MAX_DEPTH, m.maxd);
                    chk("ret_pc", RET_PC, m.ret);
                    chk("busy_at_resp", BUSY, 0);
                    chk("write_count", nw, m.is_call ? 2 : 0);
                    chk("read_count", nr, m.is_ret ? 2 : 0);
                    if (m.is_call) chk("write_data", wacc, m.pc);
                end
                nw = 0;
                nr = 0;
                wacc = '0;
            end
        end
    end

    task automatic op(input bit c, input bit r, input logic [7:0] pc);
        exp_t e;
        bit got;
        @(negedge CLK);
        e = '{code: 3'b001, pc: pc, ret: 8'h0, depth: 0, maxd: 0, lat: 1, acc: cyc + 1, is_call: 1'b0, is_ret: 1'b0};
        if (c) begin
            if (model.size() == MAXF) e.code = 3'b010;
            else begin
                model.push_back(pc);
                if (model.size() > wm) wm = model.size();
                e.lat = 3;
                e.is_call = 1'b1;
            end
        end else if (model.size() == 0) e.code = 3'b100;
        else begin
            last_ret = model.pop_back();
            e.lat = 4;
            e.is_ret = 1'b1;
        end
        e.ret = last_ret;
        e.depth = model.size();
        e.maxd = WM ? wm : 0;
        sb.push_back(e);
        CALL_REQ = c;
        RET_REQ = r;
        PC_IN = pc;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge CLK);
            got = DONE || ERR_OVF || ERR_UNF;
        end
        CALL_REQ = 1'b0;
        RET_REQ = 1'b0;
        if (!got) begin
            chk("response_timeout", 0, 1);
            if (sb.size() != 0) void'(sb.pop_front());
        end
    endtask

    task automatic mid_reset();
        @(negedge CLK);
        CALL_REQ = 1'b1;
        PC_IN = 8'h99;
        @(negedge CLK);
        @(negedge CLK);
        chk("second_push_strobe", STK_W, 1);
        RSTN = 1'b0;
        CALL_REQ = 1'b0;
        #1;
        chk("abort_outputs", {RET_PC, BUSY, DONE, ERR_OVF, ERR_UNF, DEPTH, MAX_DEPTH, STK_W, STK_R, STK_DATA_WR}, 0);
        model.delete();
        sb.delete();
        wm = 0;
        last_ret = '0;
        @(negedge CLK);
        @(negedge CLK);
        RSTN = 1'b1;
    endtask

    initial begin
        int k;
        #2;
        chk("reset_outputs", {RET_PC, BUSY, DONE, ERR_OVF, ERR_UNF, DEPTH, MAX_DEPTH, STK_W, STK_R, STK_DATA_WR}, 0);
        repeat (2) @(negedge CLK);
        RSTN = 1'b1;
        op(1, 0, 8'hA5);
        op(0, 1, 8'h00);
        op(1, 0, 8'h12);
        op(1, 0, 8'h34);
        op(1, 0, 8'h56);
        repeat (3) op(0, 1, 8'h00);
        for (int i = 0; i < MAXF; i++) op(1, 0, 8'($urandom));
        op(1, 0, 8'hEE);
        repeat (MAXF) op(0, 1, 8'h00);
        op(0, 1, 8'h00);
        op(1, 1, 8'h4B);
        mid_reset();
        op(1, 0, 8'h3C);
        op(0, 1, 8'h00);
        for (int i = 0; i < 300; i++) begin
            k = $urandom_range(0, 9);
            op(k < 5 || k == 9, k >= 5, 8'($urandom));
        end
        repeat (6) @(negedge CLK);
        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
